// File: rtl/cmdline_pkg.sv
// Shared definitions for the command-line serial link (transmit and receive).
package cmdline_pkg;

  // Transmit framer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Payload bits per 8N1 frame
  localparam int UART_DATA_BITS = 8;

  // 3.25 MHz system clock / 115200 baud, rounded
  localparam int DEFAULT_CLKS_PER_BIT = 28;

endpackage

// File: rtl/cmdline_tx_fifo.sv
// Byte FIFO between the cmdline interpreter and the UART framer.
// Synchronous write; the head byte is presented from the registered read pointer.
// A write is taken when there is room, or when a pop frees a slot in the same cycle.
module cmdline_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   COUNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               wr_ok;
  logic               rd_ok;
  logic [FIFO_AW:0]   count_n;

  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Next occupancy, so full/empty are registered alongside count
  always_comb begin
    count_n = count;
    if (wr_ok && !rd_ok)
      count_n = count + 1'b1;
    else if (!wr_ok && rd_ok)
      count_n = count - 1'b1;
  end

  // Storage array
  // NOTE: the data array has no reset; a slot is only read after it has been written, so resetting it would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy flags; pointers wrap naturally at 2**FIFO_AW
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == COUNT_FULL);
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/cmdline_uart_tx.sv
// Transmit side of the command-line serial link: buffers reply bytes and
// serialises them as 8N1 frames on txd, with flow status and a sticky overflow.
module cmdline_uart_tx
  import cmdline_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] send_data,
  input  logic       send_strobe,
  output logic       tx_full,
  output logic       tx_idle,
  output logic       overflow,
  output logic       txd
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

  tx_state_t        state;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic [7:0]       fifo_head;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  logic             bit_end;
  logic             stop_end;
  logic             pop;
  logic             tx_idle_n;
  logic             line_bit;

  cmdline_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (send_strobe),
    .wr_data (send_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (tx_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Pop decisions, next idle status and the line level for the current state
  // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    bit_end   = (baud_cnt == '0);
    stop_end  = (state == STOP) && bit_end;
    pop       = !fifo_empty && ((state == IDLE) || stop_end);
    // Idle next cycle only if nothing is queued, nothing arrives, and no frame continues
    tx_idle_n = (fifo_count == '0) && !send_strobe && ((state == IDLE) || stop_end);
    line_bit  = 1'b1;
    unique case (state)
      IDLE:  line_bit = 1'b1;
      START: line_bit = 1'b0;
      DATA:  line_bit = shift_reg[0];
      STOP:  line_bit = 1'b1;
      default: line_bit = 1'b1;
    endcase
  end

  // Framer FSM with baud counter, shift register and registered status outputs
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      txd       <= 1'b1;
      tx_idle   <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      // txd is one register stage behind the state: glitch-free line output
      txd     <= line_bit;
      tx_idle <= tx_idle_n;
      if (send_strobe && tx_full && !pop)
        overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= fifo_head;
            baud_cnt  <= BAUD_RELOAD;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              // Back-to-back: next start bit follows the stop bit with no gap
              shift_reg <= fifo_head;
              baud_cnt  <= BAUD_RELOAD;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
